// File: rtl/delay_align_controller_pkg.sv
// Shared definitions for the receive-side delay alignment sequencer.
package delay_align_controller_pkg;

  // Width of the filter_delay / symbol-delay select buses
  localparam int unsigned SEL_W = 4;
  localparam int unsigned STATE_W = 3;

  // Default sweep configuration, reused by the top level and the bench
  localparam int unsigned FILT_MAX_DEF     = 15;
  localparam int unsigned SYM_MAX_DEF      = 15;
  localparam int unsigned SETTLE_SYMS_DEF  = 32;
  localparam int unsigned WINDOW_LOG2_DEF  = 10;
  localparam int unsigned DEFAULT_FILT_DEF = 10;
  localparam int unsigned DEFAULT_SYM_DEF  = 0;

  // Sequencer states; encoding is visible on the state_dbg probe
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_EVAL    = 3'd3,
    ST_APPLY   = 3'd4
  } state_t;

endpackage

// File: rtl/delay_align_controller_sym_window_counter.sv
// Symbol-enable counter with programmable terminal count and a qualified
// error counter. The terminal-count flag is combinational so the caller can
// change state on the very edge that carries the last counted symbol.
module delay_align_controller_sym_window_counter #(
  parameter int unsigned CNT_W = 11
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_ena,
  input  logic             i_err,
  input  logic             i_count_err,
  input  logic [CNT_W-1:0] i_term,
  output logic             o_tc_c,
  output logic [CNT_W-1:0] o_err_cnt
);

  logic [CNT_W-1:0] r_sym_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic             w_last;

  assign w_last    = (r_sym_cnt == (i_term - CNT_W'(1)));
  assign o_tc_c    = i_ena && w_last;
  assign o_err_cnt = r_err_cnt;

  // Symbol counter: wraps to zero on the terminal pulse, clear has priority
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sym_cnt <= '0;
    end else if (i_clear) begin
      r_sym_cnt <= '0;
    end else if (i_ena) begin
      r_sym_cnt <= w_last ? '0 : r_sym_cnt + CNT_W'(1);
    end
  end

  // Error counter: only errors coincident with a symbol enable are counted
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err_cnt <= '0;
    end else if (i_clear) begin
      r_err_cnt <= '0;
    end else if (i_ena && i_err && i_count_err) begin
      r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/delay_align_controller.sv
// Sweeps every (filter, symbol) delay pair, measures comparator errors over a
// fixed window after a settling period, and applies the best pair.
module delay_align_controller
  import delay_align_controller_pkg::*;
#(
  parameter int unsigned FILT_MAX     = FILT_MAX_DEF,
  parameter int unsigned SYM_MAX      = SYM_MAX_DEF,
  parameter int unsigned SETTLE_SYMS  = SETTLE_SYMS_DEF,
  parameter int unsigned WINDOW_LOG2  = WINDOW_LOG2_DEF,
  parameter int unsigned DEFAULT_FILT = DEFAULT_FILT_DEF,
  parameter int unsigned DEFAULT_SYM  = DEFAULT_SYM_DEF
) (
  input  logic                 i_sys_clk,
  input  logic                 i_reset,
  input  logic                 i_sym_clk_ena,
  input  logic                 i_sym_error,
  input  logic                 i_start,
  output logic [SEL_W-1:0]     o_filt_delay_sel,
  output logic [SEL_W-1:0]     o_sym_delay_sel,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_locked,
  output logic [WINDOW_LOG2:0] o_best_err,
  output logic [STATE_W-1:0]   o_state_dbg
);

  localparam int unsigned CNT_W = WINDOW_LOG2 + 1;
  localparam logic [CNT_W-1:0] WINDOW_LEN = {1'b1, {WINDOW_LOG2{1'b0}}};
  localparam logic [CNT_W-1:0] SETTLE_LEN = CNT_W'(SETTLE_SYMS);

  state_t           r_state, w_state_nxt;
  logic [SEL_W-1:0] r_filt, w_filt_nxt;
  logic [SEL_W-1:0] r_sym, w_sym_nxt;
  logic [SEL_W-1:0] r_best_filt, w_best_filt_nxt;
  logic [SEL_W-1:0] r_best_sym, w_best_sym_nxt;
  logic [CNT_W-1:0] r_best, w_best_nxt;
  logic [CNT_W-1:0] r_best_err, w_best_err_nxt;
  logic             r_locked, w_locked_nxt;
  logic             r_done, w_done_nxt;
  logic             r_busy, w_busy_nxt;

  logic             w_cnt_clear;
  logic             w_cnt_ena;
  logic             w_count_err;
  logic [CNT_W-1:0] w_term;
  logic             w_tc;
  logic [CNT_W-1:0] w_err_cnt;
  logic             w_better;
  logic             w_last_pair;

  assign o_filt_delay_sel = r_filt;
  assign o_sym_delay_sel  = r_sym;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_locked         = r_locked;
  assign o_best_err       = r_best_err;
  assign o_state_dbg      = r_state;

  // Counter only runs while a settling or measurement window is open
  assign w_cnt_clear = ((r_state == ST_IDLE) && i_start) || (r_state == ST_EVAL);
  assign w_cnt_ena   = i_sym_clk_ena && ((r_state == ST_SETTLE) || (r_state == ST_MEASURE));
  assign w_count_err = (r_state == ST_MEASURE);
  assign w_term      = (r_state == ST_MEASURE) ? WINDOW_LEN : SETTLE_LEN;

  delay_align_controller_sym_window_counter #(
    .CNT_W(CNT_W)
  ) u_sym_window_counter (
    .i_clk       (i_sys_clk),
    .i_rst       (i_reset),
    .i_clear     (w_cnt_clear),
    .i_ena       (w_cnt_ena),
    .i_err       (i_sym_error),
    .i_count_err (w_count_err),
    .i_term      (w_term),
    .o_tc_c      (w_tc),
    .o_err_cnt   (w_err_cnt)
  );

  assign w_better    = (w_err_cnt < r_best);
  assign w_last_pair = (r_filt == SEL_W'(FILT_MAX)) && (r_sym == SEL_W'(SYM_MAX));

  // State and output registers
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_filt      <= SEL_W'(DEFAULT_FILT);
      r_sym       <= SEL_W'(DEFAULT_SYM);
      r_best_filt <= '0;
      r_best_sym  <= '0;
      r_best      <= '1;
      r_best_err  <= '1;
      r_locked    <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_filt      <= w_filt_nxt;
      r_sym       <= w_sym_nxt;
      r_best_filt <= w_best_filt_nxt;
      r_best_sym  <= w_best_sym_nxt;
      r_best      <= w_best_nxt;
      r_best_err  <= w_best_err_nxt;
      r_locked    <= w_locked_nxt;
      r_done      <= w_done_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Next-state and next-output logic; results are staged on the EVAL->APPLY
  // edge so they are already visible during the APPLY cycle that pulses done
  always_comb begin
    w_state_nxt     = r_state;
    w_filt_nxt      = r_filt;
    w_sym_nxt       = r_sym;
    w_best_filt_nxt = r_best_filt;
    w_best_sym_nxt  = r_best_sym;
    w_best_nxt      = r_best;
    w_best_err_nxt  = r_best_err;
    w_locked_nxt    = r_locked;
    w_done_nxt      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt    = ST_SETTLE;
          w_filt_nxt     = '0;
          w_sym_nxt      = '0;
          w_best_nxt     = '1;
          w_best_err_nxt = '1;
          w_locked_nxt   = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (w_tc) begin
          w_state_nxt = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (w_tc) begin
          w_state_nxt = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (w_better) begin
          w_best_nxt      = w_err_cnt;
          w_best_filt_nxt = r_filt;
          w_best_sym_nxt  = r_sym;
        end
        if (w_last_pair) begin
          w_state_nxt    = ST_APPLY;
          w_filt_nxt     = w_best_filt_nxt;
          w_sym_nxt      = w_best_sym_nxt;
          w_best_err_nxt = w_best_nxt;
          w_locked_nxt   = (w_best_nxt == '0);
          w_done_nxt     = 1'b1;
        end else begin
          w_state_nxt = ST_SETTLE;
          if (r_sym == SEL_W'(SYM_MAX)) begin
            w_sym_nxt  = '0;
            w_filt_nxt = r_filt + SEL_W'(1);
          end else begin
            w_sym_nxt = r_sym + SEL_W'(1);
          end
        end
      end
      ST_APPLY: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

endmodule

// File: tb/tb_delay_align_controller.sv
// Randomized scoreboard bench for delay_align_controller on a reduced sweep.
module tb_delay_align_controller;

  localparam int FILT_MAX     = 1;
  localparam int SYM_MAX      = 3;
  localparam int SETTLE_SYMS  = 2;
  localparam int WINDOW_LOG2  = 3;
  localparam int WINDOW       = 1 << WINDOW_LOG2;
  localparam int SLOTS        = SETTLE_SYMS + WINDOW;
  localparam int SWEEP_ENAS   = (FILT_MAX + 1) * (SYM_MAX + 1) * SLOTS;
  localparam int TIMEOUT      = 4000;

  logic       clk;
  logic       i_reset;
  logic       i_sym_clk_ena;
  logic       i_sym_error;
  logic       i_start;
  logic [3:0] o_filt_delay_sel;
  logic [3:0] o_sym_delay_sel;
  logic       o_busy;
  logic       o_done;
  logic       o_locked;
  logic [3:0] o_best_err;
  logic [2:0] o_state_dbg;

  delay_align_controller #(
    .FILT_MAX     (FILT_MAX),
    .SYM_MAX      (SYM_MAX),
    .SETTLE_SYMS  (SETTLE_SYMS),
    .WINDOW_LOG2  (WINDOW_LOG2),
    .DEFAULT_FILT (10),
    .DEFAULT_SYM  (0)
  ) dut (
    .i_sys_clk        (clk),
    .i_reset          (i_reset),
    .i_sym_clk_ena    (i_sym_clk_ena),
    .i_sym_error      (i_sym_error),
    .i_start          (i_start),
    .o_filt_delay_sel (o_filt_delay_sel),
    .o_sym_delay_sel  (o_sym_delay_sel),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_locked         (o_locked),
    .o_best_err       (o_best_err),
    .o_state_dbg      (o_state_dbg)
  );

  typedef struct {
    int filt;
    int sym;
    int best_err;
    int locked;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          done_cnt = 0;
  int          phase = 0;
  int          slot = 0;
  int          ena_seen = 0;
  bit          between_mode = 0;
  int          cnt  [2][4];
  logic [9:0]  mask [2][4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Measurement-window error pattern with exactly k errors; settle slots get noise
  function automatic logic [9:0] make_mask(input int k);
    logic [7:0] m;
    logic [1:0] noise;
    int placed;
    m = '0;
    placed = 0;
    while (placed < k) begin
      int p;
      p = int'($urandom_range(0, 7));
      if (!m[p]) begin
        m[p] = 1'b1;
        placed++;
      end
    end
    noise = 2'($urandom_range(0, 3));
    return {m, noise};
  endfunction

  task automatic build_masks();
    for (int f = 0; f <= FILT_MAX; f++)
      for (int s = 0; s <= SYM_MAX; s++)
        mask[f][s] = make_mask(cnt[f][s]);
  endtask

  // Reference: first pair in sweep order with the minimum error count
  task automatic push_expected();
    exp_t e;
    int best;
    best = 1 << 30;
    e.filt = 0;
    e.sym = 0;
    for (int f = 0; f <= FILT_MAX; f++)
      for (int s = 0; s <= SYM_MAX; s++)
        if (cnt[f][s] < best) begin
          best = cnt[f][s];
          e.filt = f;
          e.sym = s;
        end
    e.best_err = best;
    e.locked = (best == 0) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  // Channel model: error pattern depends on the delay pair the DUT applies
  initial begin
    logic [3:0] last_f;
    logic [3:0] last_s;
    logic       last_busy;
    i_sym_clk_ena = 1'b0;
    i_sym_error = 1'b0;
    last_f = '0;
    last_s = '0;
    last_busy = 1'b0;
    forever begin
      @(negedge clk);
      if ((o_busy && !last_busy) || (o_filt_delay_sel != last_f) || (o_sym_delay_sel != last_s))
        slot = 0;
      if (o_busy && !last_busy)
        ena_seen = 0;
      last_f = o_filt_delay_sel;
      last_s = o_sym_delay_sel;
      last_busy = o_busy;
      phase = (phase + 1) % 16;
      i_sym_clk_ena = (phase == 15);
      if (between_mode)
        i_sym_error = !i_sym_clk_ena;
      else if (i_sym_clk_ena && o_busy && (o_filt_delay_sel <= 4'(FILT_MAX)) && (slot < SLOTS))
        i_sym_error = mask[int'(o_filt_delay_sel)][int'(o_sym_delay_sel)][slot];
      else
        i_sym_error = 1'($urandom_range(0, 1));
      if (i_sym_clk_ena && o_busy) begin
        slot++;
        ena_seen++;
      end
    end
  end

  // Monitor: compare the applied result whenever done pulses
  initial begin
    forever begin
      @(negedge clk);
      if (o_done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("done_without_expectation", exp_q.size(), 1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result_filt", int'(o_filt_delay_sel), e.filt);
          check("result_sym", int'(o_sym_delay_sel), e.sym);
          check("result_best_err", int'(o_best_err), e.best_err);
          check("result_locked", int'(o_locked), e.locked);
          check("sweep_enables", ena_seen, SWEEP_ENAS);
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    while (phase != 4) @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int prev, input string name);
    int n;
    n = 0;
    while ((done_cnt == prev) && (n < TIMEOUT)) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, (done_cnt > prev) ? 1 : 0, 1);
    repeat (3) @(negedge clk);
    check({name, "_busy_after"}, int'(o_busy), 0);
    check({name, "_state_after"}, int'(o_state_dbg), 0);
  endtask

  task automatic run_sweep(input string name);
    int prev;
    build_masks();
    push_expected();
    prev = done_cnt;
    pulse_start();
    wait_done(prev, name);
  endtask

  task automatic fill_all(input int k);
    for (int f = 0; f <= FILT_MAX; f++)
      for (int s = 0; s <= SYM_MAX; s++)
        cnt[f][s] = k;
  endtask

  task automatic fill_random(input int lo, input int hi);
    for (int f = 0; f <= FILT_MAX; f++)
      for (int s = 0; s <= SYM_MAX; s++)
        cnt[f][s] = int'($urandom_range(hi, lo));
  endtask

  initial begin
    i_reset = 1'b1;
    i_start = 1'b0;
    fill_all(0);
    repeat (3) @(negedge clk);
    i_reset = 1'b0;

    // Reset state held while idle
    repeat (40) @(negedge clk);
    check("rst_filt", int'(o_filt_delay_sel), 10);
    check("rst_sym", int'(o_sym_delay_sel), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_locked", int'(o_locked), 0);
    check("rst_best_err", int'(o_best_err), 15);
    check("rst_state", int'(o_state_dbg), 0);

    // Only (1,2) is error free
    fill_all(WINDOW);
    cnt[1][2] = 0;
    run_sweep("single_clean");

    // Ties at the minimum keep the earlier pair
    fill_all(3);
    cnt[0][1] = 1;
    cnt[1][3] = 1;
    run_sweep("tie");

    // Errors only between enables; starts during MEASURE are ignored
    begin
      int prev;
      int n;
      between_mode = 1'b1;
      fill_all(0);
      build_masks();
      push_expected();
      prev = done_cnt;
      pulse_start();
      for (int i = 0; i < 3; i++) begin
        n = 0;
        while ((o_state_dbg != 3'd2) && (n < TIMEOUT)) begin
          @(negedge clk);
          n++;
        end
        pulse_start();
        repeat (150) @(negedge clk);
      end
      wait_done(prev, "between");
      repeat (40) @(negedge clk);
      check("between_done_count", done_cnt - prev, 1);
      check("between_no_restart", int'(o_busy), 0);
      between_mode = 1'b0;
    end

    // Asynchronous reset in the middle of measuring pair (0,2)
    begin
      int n;
      fill_random(1, WINDOW);
      build_masks();
      push_expected();
      pulse_start();
      n = 0;
      while (!((o_filt_delay_sel == 4'd0) && (o_sym_delay_sel == 4'd2) && (o_state_dbg == 3'd2))
             && (n < TIMEOUT)) begin
        @(negedge clk);
        n++;
      end
      check("reach_pair_0_2_measure", (n < TIMEOUT) ? 1 : 0, 1);
      repeat (20) @(negedge clk);
      @(posedge clk);
      #2;
      i_reset = 1'b1;
      #1;
      check("abort_filt", int'(o_filt_delay_sel), 10);
      check("abort_sym", int'(o_sym_delay_sel), 0);
      check("abort_busy", int'(o_busy), 0);
      check("abort_best_err", int'(o_best_err), 15);
      check("abort_locked", int'(o_locked), 0);
      check("abort_state", int'(o_state_dbg), 0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      i_reset = 1'b0;
      repeat (5) @(negedge clk);
    end

    // Full sweeps after the abort with random error counts
    fill_random(0, WINDOW);
    run_sweep("after_abort");
    fill_random(2, WINDOW);
    run_sweep("random_nolock");

    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
